// File: rtl/pad_cell_pkg.sv
// Shared types and limits for the simulation input pad cell.
package pad_cell_pkg;

   localparam int SYNC_STAGES_MIN = 2;

   typedef struct {
      logic filt;
      logic rise;
      logic fall;
   } pad_filt_out_t;

endpackage

// File: rtl/pad_input_filter_ch.sv
// One input channel: synchroniser chain, stability counter and edge-pulse registers.
module pad_input_filter_ch
   import pad_cell_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int FILTER_CNT_W = 4,
   parameter int PADATTR_RND  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    pad,
   input  logic                    en,
   input  logic [FILTER_CNT_W-1:0] thresh,
   input  logic [PADATTR_RND-1:0]  attr,
   output logic                    sync,
   output pad_filt_out_t           out
);

   // Undersized chains are silently widened to the safe minimum.
   localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

   logic [SYNC_N-1:0]       chain;
   logic [FILTER_CNT_W-1:0] cnt;
   logic [FILTER_CNT_W-1:0] cnt_next;
   logic                    filt_next;
   pad_filt_out_t           out_q;

   logic unused_attr;
   assign unused_attr = ^attr;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) chain <= '0;
      else         chain <= {chain[SYNC_N-2:0], pad};
   end

   assign sync = chain[SYNC_N-1];

   // Count cycles of disagreement; commit once the count has reached the threshold.
   always_comb begin
      filt_next = out_q.filt;
      cnt_next  = '0;
      if (!en) begin
         filt_next = sync;
      end else if (sync != out_q.filt) begin
         if (cnt >= thresh) filt_next = sync;
         else               cnt_next  = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt        <= '0;
         out_q.filt <= 1'b0;
         out_q.rise <= 1'b0;
         out_q.fall <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         out_q.filt <= filt_next;
         out_q.rise <= filt_next & ~out_q.filt;
         out_q.fall <= ~filt_next & out_q.filt;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/pad_input_sync_filter.sv
// Multi-channel input pad: raw, synchronised and debounced views of each pad.
module pad_input_sync_filter
   import pad_cell_pkg::*;
#(
   parameter int NUM_PADS     = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int FILTER_CNT_W = 4,
   parameter int PADATTR      = 16,
   parameter int PADATTR_RND  = (PADATTR == 0) ? 1 : PADATTR
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   inout  wire  [NUM_PADS-1:0]             pad_io,
   input  logic [NUM_PADS*PADATTR_RND-1:0] pad_attributes_i,
   input  logic [NUM_PADS-1:0]             filter_en_i,
   input  logic [FILTER_CNT_W-1:0]         filter_thresh_i,
   output logic [NUM_PADS-1:0]             pad_out_o,
   output logic [NUM_PADS-1:0]             pad_sync_o,
   output logic [NUM_PADS-1:0]             pad_filt_o,
   output logic [NUM_PADS-1:0]             rise_o,
   output logic [NUM_PADS-1:0]             fall_o
);

   // Pads are only ever read here; nothing drives pad_io.
   assign pad_out_o = pad_io;

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_ch
      pad_filt_out_t ch_out;

      pad_input_filter_ch #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CNT_W (FILTER_CNT_W),
         .PADATTR_RND  (PADATTR_RND)
      ) u_ch (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .pad    (pad_io[i]),
         .en     (filter_en_i[i]),
         .thresh (filter_thresh_i),
         .attr   (pad_attributes_i[i*PADATTR_RND +: PADATTR_RND]),
         .sync   (pad_sync_o[i]),
         .out    (ch_out)
      );

      assign pad_filt_o[i] = ch_out.filt;
      assign rise_o[i]     = ch_out.rise;
      assign fall_o[i]     = ch_out.fall;
   end

endmodule

// File: tb/tb_pad_input_sync_filter.sv
// Directed vector bench for pad_input_sync_filter (8 pads, 2 sync stages, 4-bit threshold).
module tb_pad_input_sync_filter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   pad_drv;
   wire  [7:0]   pad_w;
   logic [127:0] attr;
   logic [7:0]   en;
   logic [3:0]   thresh;
   logic [7:0]   pad_out, pad_sync, pad_filt, rise, fall;

   assign pad_w = pad_drv;
   always #5 clk = ~clk;

   pad_input_sync_filter dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .pad_io           (pad_w),
      .pad_attributes_i (attr),
      .filter_en_i      (en),
      .filter_thresh_i  (thresh),
      .pad_out_o        (pad_out),
      .pad_sync_o       (pad_sync),
      .pad_filt_o       (pad_filt),
      .rise_o           (rise),
      .fall_o           (fall)
   );

   // Inputs are held across one rising edge; expectations are the outputs just after it.
   typedef struct {
      logic       rst_n;
      logic [7:0] pad;
      logic [7:0] en;
      logic [3:0] t;
      logic [7:0] sync;
      logic [7:0] filt;
      logic [7:0] rise;
      logic [7:0] fall;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic add(input logic r, input logic [7:0] p, input logic [7:0] e, input logic [3:0] t,
                      input logic [7:0] s, input logic [7:0] f, input logic [7:0] ri, input logic [7:0] fa);
      vec_t v;
      v.rst_n = r; v.pad = p; v.en = e; v.t = t;
      v.sync = s; v.filt = f; v.rise = ri; v.fall = fa;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] s, input logic [7:0] f,
                        input logic [7:0] ri, input logic [7:0] fa);
      n_vec++;
      if (pad_sync !== s || pad_filt !== f || rise !== ri || fall !== fa ||
          pad_out !== pad_drv || (rise & fall) != 8'h00) begin
         n_fail++;
         $display("FAIL %s: got sync=%h filt=%h rise=%h fall=%h out=%h, expected sync=%h filt=%h rise=%h fall=%h out=%h",
                  name, pad_sync, pad_filt, rise, fall, pad_out, s, f, ri, fa, pad_drv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      attr    = {8{16'hA5C3}};
      rst_n   = 1'b0;
      pad_drv = 8'hFF;
      en      = 8'hFF;
      thresh  = 4'd3;

      // reset with all pads high
      for (int i = 0; i < 3; i++) add(0, 8'hFF, 8'hFF, 3, 8'h00, 8'h00, 8'h00, 8'h00);
      add(1, 8'h00, 8'hFF, 3, 8'h00, 8'h00, 8'h00, 8'h00);
      // clean rise on pad0, T=3
      add(1, 8'h01, 8'hFF, 3, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) add(1, 8'h01, 8'hFF, 3, 8'h01, 8'h00, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFF, 3, 8'h01, 8'h01, 8'h01, 8'h00);
      add(1, 8'h01, 8'hFF, 3, 8'h01, 8'h01, 8'h00, 8'h00);
      // 3-cycle glitch on pad1
      add(1, 8'h03, 8'hFF, 3, 8'h01, 8'h01, 8'h00, 8'h00);
      add(1, 8'h03, 8'hFF, 3, 8'h03, 8'h01, 8'h00, 8'h00);
      add(1, 8'h03, 8'hFF, 3, 8'h03, 8'h01, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFF, 3, 8'h03, 8'h01, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFF, 3, 8'h01, 8'h01, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFF, 3, 8'h01, 8'h01, 8'h00, 8'h00);
      // filter bypass on pad2, toggling every 4 cycles
      add(1, 8'h05, 8'hFB, 3, 8'h01, 8'h01, 8'h00, 8'h00);
      add(1, 8'h05, 8'hFB, 3, 8'h05, 8'h01, 8'h00, 8'h00);
      add(1, 8'h05, 8'hFB, 3, 8'h05, 8'h05, 8'h04, 8'h00);
      add(1, 8'h05, 8'hFB, 3, 8'h05, 8'h05, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFB, 3, 8'h05, 8'h05, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFB, 3, 8'h01, 8'h05, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFB, 3, 8'h01, 8'h01, 8'h00, 8'h04);
      add(1, 8'h01, 8'hFB, 3, 8'h01, 8'h01, 8'h00, 8'h00);
      add(1, 8'h05, 8'hFB, 3, 8'h01, 8'h01, 8'h00, 8'h00);
      add(1, 8'h05, 8'hFB, 3, 8'h05, 8'h01, 8'h00, 8'h00);
      add(1, 8'h05, 8'hFB, 3, 8'h05, 8'h05, 8'h04, 8'h00);
      add(1, 8'h05, 8'hFB, 3, 8'h05, 8'h05, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFB, 3, 8'h05, 8'h05, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFB, 3, 8'h01, 8'h05, 8'h00, 8'h00);
      add(1, 8'h01, 8'hFB, 3, 8'h01, 8'h01, 8'h00, 8'h04);
      add(1, 8'h01, 8'hFB, 3, 8'h01, 8'h01, 8'h00, 8'h00);
      // T=15 on pad3, then lowered to 2 mid-count
      add(1, 8'h09, 8'hFF, 15, 8'h01, 8'h01, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) add(1, 8'h09, 8'hFF, 15, 8'h09, 8'h01, 8'h00, 8'h00);
      add(1, 8'h09, 8'hFF, 2, 8'h09, 8'h09, 8'h08, 8'h00);
      add(1, 8'h09, 8'hFF, 2, 8'h09, 8'h09, 8'h00, 8'h00);
      // T=8, pad4 counting, then a one-cycle reset
      add(1, 8'h19, 8'hFF, 8, 8'h09, 8'h09, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) add(1, 8'h19, 8'hFF, 8, 8'h19, 8'h09, 8'h00, 8'h00);
      add(0, 8'h19, 8'hFF, 8, 8'h00, 8'h00, 8'h00, 8'h00);
      add(1, 8'h19, 8'hFF, 8, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 9; i++) add(1, 8'h19, 8'hFF, 8, 8'h19, 8'h00, 8'h00, 8'h00);
      add(1, 8'h19, 8'hFF, 8, 8'h19, 8'h19, 8'h19, 8'h00);
      add(1, 8'h19, 8'hFF, 8, 8'h19, 8'h19, 8'h00, 8'h00);
      // T=0: registered pass-through of a falling edge
      add(1, 8'h00, 8'hFF, 0, 8'h19, 8'h19, 8'h00, 8'h00);
      add(1, 8'h00, 8'hFF, 0, 8'h00, 8'h19, 8'h00, 8'h00);
      add(1, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h19);
      add(1, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00);

      foreach (vecs[k]) begin
         rst_n   = vecs[k].rst_n;
         pad_drv = vecs[k].pad;
         en      = vecs[k].en;
         thresh  = vecs[k].t;
         tick();
         check($sformatf("vec%0d", k), vecs[k].sync, vecs[k].filt, vecs[k].rise, vecs[k].fall);
      end

      // Maximum threshold: pad5 must commit exactly 2+16 cycles after it rises.
      pad_drv = 8'h20;
      thresh  = 4'd15;
      n = 0;
      do begin
         tick();
         n++;
      end while (pad_filt[5] !== 1'b1 && n < 40);
      n_vec++;
      if (n != 18) begin
         n_fail++;
         $display("FAIL t15_latency: got %0d cycles, expected 18", n);
      end
      check("t15_commit", 8'h20, 8'h20, 8'h20, 8'h00);
      tick();
      check("t15_after", 8'h20, 8'h20, 8'h00, 8'h00);

      // Disabling the filter mid-count makes the channel follow sync immediately.
      pad_drv = 8'h00;
      tick();
      check("dis_0", 8'h20, 8'h20, 8'h00, 8'h00);
      tick();
      check("dis_1", 8'h00, 8'h20, 8'h00, 8'h00);
      en = 8'hDF;
      tick();
      check("dis_2", 8'h00, 8'h00, 8'h00, 8'h20);
      tick();
      check("dis_3", 8'h00, 8'h00, 8'h00, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
